qdec_cabac_slice_seq: RTL and testbench
=======================================

Name: qdec_cabac_slice_seq

Overview:
Slice-level sequencer for the CABAC decoder. It accepts one slice descriptor (VPS/SPS/PPS/slice-header config words) from the host side. It programs the five config registers and then the START register over a simple register write bus. It then waits for the CABAC done or error interrupt while counting CTU completions and watching for a stall, and finally reports one status record per slice.

Parameters:
ADDR_VPS_0, 16'h0000, register address of VPS word 0
ADDR_SPS_0, 16'h0004, register address of SPS word 0
ADDR_SPS_1, 16'h0008, register address of SPS word 1
ADDR_PPS_0, 16'h000C, register address of PPS word 0
ADDR_SLICE_HEADER_0, 16'h0010, register address of slice header word 0
ADDR_START, 16'h0014, register address of the CABAC start register
TIMEOUT_CYCLES, 1000000, maximum cycles with no CTU progress in WAIT before timeout (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
desc_vld  in  1  slice descriptor valid
desc_rdy  out  1  sequencer can accept a descriptor
desc_vps0  in  32  VPS word 0
desc_sps0  in  32  SPS word 0
desc_sps1  in  32  SPS word 1
desc_pps0  in  32  PPS word 0
desc_sh0  in  32  slice header word 0
reg_wr  out  1  register write request
reg_addr  out  16  write address
reg_wdata  out  32  write data
reg_ack  in  1  write accepted; single-cycle pulse
cabac_done  in  1  CABAC done interrupt
cabac_error  in  1  CABAC error interrupt
cabac_ctu_done  in  1  CTU-done pulse
abort  in  1  host abort request; level, sampled each cycle
stat_vld  out  1  status record valid
stat_rdy  in  1  status consumer ready
stat_code  out  2  0=done, 1=error, 2=timeout, 3=aborted
stat_ctu_cnt  out  16  CTUs completed in this slice; saturates at 16'hFFFF
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: desc_rdy=0 during reset and 1 in the first cycle after reset. reg_wr=0, reg_addr=0, reg_wdata=0, stat_vld=0, stat_code=0, stat_ctu_cnt=0, busy=0.
- The FSM has four states: IDLE, WR, WAIT and REPORT. Asserting rst_n low returns the FSM to IDLE from any state on the next edge and drops any in-flight write.
- IDLE:
  - desc_rdy=1.
  - On desc_vld&&desc_rdy, capture all five words, clear the CTU count and the write index, and go to WR.
  - reg_wr rises in the next cycle.
- WR:
  - The write index runs 0..5 and maps to the registers VPS_0, SPS_0, SPS_1, PPS_0, SLICE_HEADER_0 and START.
  - The START write carries wdata=32'h1.
  - reg_wr=1 and reg_addr/reg_wdata are held stable until the cycle in which reg_ack=1.
  - In the ack cycle the index advances; the next address is presented in the following cycle, so back-to-back writes are allowed and reg_wr stays high.
  - After the START ack: reg_wr=0, clear the timeout counter, go to WAIT.
  - The minimum time from descriptor accept to entering WAIT is 6 cycles when reg_ack returns in the same cycle as each request.
- WAIT:
  - Each cabac_ctu_done pulse increments stat_ctu_cnt, saturating at 16'hFFFF, and clears the timeout counter.
  - Otherwise the timeout counter increments each cycle.
  - Exit priority, checked every cycle:
    1. cabac_error -> code 1
    2. cabac_done -> code 2 is not used here; code 0
    3. abort -> code 3
    4. timeout counter == TIMEOUT_CYCLES-1 -> code 2
  - A cabac_ctu_done in the same cycle as the exit event is still counted.
  - On exit: latch stat_code, go to REPORT.
- Abort in WR:
  - The current transaction is never dropped.
  - Once the pending write's ack is received, go to REPORT with code 3.
  - Remaining writes, including START, are skipped.
- REPORT:
  - stat_vld=1 with stat_code and stat_ctu_cnt held stable.
  - On stat_vld&&stat_rdy, go to IDLE; stat_vld falls in the next cycle.
  - Interrupt pulses in REPORT or IDLE are ignored and not counted.
- stat_ctu_cnt keeps its value after REPORT until the next descriptor is accepted.
- Only one slice is in flight at a time; desc_rdy=0 whenever busy=1.

Test Plan:
- Nominal: desc_vld with vps0=0, sps0=32'h033F_1DF0, sps1=32'h0200_3233, pps0=32'h001A_4290, sh0=32'h0019_047E; reg_ack in the same cycle. Expect 6 consecutive writes to addresses 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14 with the matching data and 1 for START. Then drive 3 ctu_done pulses followed by done. Expect stat_vld with code 0 and ctu_cnt 3.
- Slow ack: reg_ack delayed 4 cycles per write. Expect addr/data held stable for 5 cycles each and exactly one write per address.
- Error beats done: cabac_error, cabac_done and ctu_done all in the same cycle after 2 CTUs. Expect code 1 and ctu_cnt 3.
- Timeout: TIMEOUT_CYCLES=16 with one ctu_done at cycle 10 of WAIT and nothing after. Expect code 2 exactly 16 cycles after that pulse, with ctu_cnt 1.
- Abort mid-WR: assert abort while the SPS_1 write is pending. Expect SPS_1 to complete on its ack, no PPS_0, SLICE_HEADER_0 or START writes, then code 3 with ctu_cnt 0.
- Backpressure/reset: hold stat_rdy=0 for 10 cycles. Expect stat_vld and the status fields stable and desc_rdy=0; after the handshake desc_rdy=1. Drive rst_n=0 during WAIT. Expect all outputs at reset values on the next edge.

Source files
------------

// File: rtl/qdec_cabac_slice_seq_if.sv
// Bundle of the descriptor, register-bus, interrupt and status signals of the
// CABAC slice sequencer. The master side is the sequencer itself.
//
// Handshake semantics: a transfer on a valid/ready pair (desc_vld/desc_rdy,
// stat_vld/stat_rdy) happens on the rising clock edge where both are high. The
// payload must stay stable while valid is high and ready is low. The sequencer
// never drops stat_vld without a handshake. On the register bus, reg_wr with
// reg_addr/reg_wdata is held until the single-cycle reg_ack pulse.
interface qdec_cabac_slice_seq_if;
    logic        desc_vld;
    logic        desc_rdy;
    logic [31:0] desc_vps0;
    logic [31:0] desc_sps0;
    logic [31:0] desc_sps1;
    logic [31:0] desc_pps0;
    logic [31:0] desc_sh0;
    logic        reg_wr;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic        cabac_done;
    logic        cabac_error;
    logic        cabac_ctu_done;
    logic        abort;
    logic        stat_vld;
    logic        stat_rdy;
    logic [1:0]  stat_code;
    logic [15:0] stat_ctu_cnt;
    logic        busy;
    logic [1:0]  dbg_state;   // 0=IDLE 1=WR 2=WAIT 3=REPORT

    modport master (
        input  desc_vld, desc_vps0, desc_sps0, desc_sps1, desc_pps0, desc_sh0,
        input  reg_ack, cabac_done, cabac_error, cabac_ctu_done, abort, stat_rdy,
        output desc_rdy, reg_wr, reg_addr, reg_wdata,
        output stat_vld, stat_code, stat_ctu_cnt, busy, dbg_state
    );

    modport slave (
        output desc_vld, desc_vps0, desc_sps0, desc_sps1, desc_pps0, desc_sh0,
        output reg_ack, cabac_done, cabac_error, cabac_ctu_done, abort, stat_rdy,
        input  desc_rdy, reg_wr, reg_addr, reg_wdata,
        input  stat_vld, stat_code, stat_ctu_cnt, busy, dbg_state
    );
endinterface

// File: rtl/qdec_cabac_slice_seq.sv
// CABAC slice sequencer: takes one slice descriptor, writes the five config
// registers and START, waits for done/error/abort/timeout while counting CTUs,
// then presents one status record.
module qdec_cabac_slice_seq #(
    parameter logic [15:0] ADDR_VPS_0          = 16'h0000,
    parameter logic [15:0] ADDR_SPS_0          = 16'h0004,
    parameter logic [15:0] ADDR_SPS_1          = 16'h0008,
    parameter logic [15:0] ADDR_PPS_0          = 16'h000C,
    parameter logic [15:0] ADDR_SLICE_HEADER_0 = 16'h0010,
    parameter logic [15:0] ADDR_START          = 16'h0014,
    parameter int          TIMEOUT_CYCLES      = 1000000
) (
    input logic                    clk,
    input logic                    rst_n,
    qdec_cabac_slice_seq_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    wrIdx;
    logic [2:0]    nxtIdx;
    logic [15:0]   nxtAddr;
    logic [31:0]   nxtData;
    logic [31:0]   vps0, sps0, sps1, pps0, sh0;
    logic          abortSeen;
    logic [TW-1:0] toCnt;
    logic [15:0]   ctuCnt;

    assign nxtIdx           = wrIdx + 3'd1;
    assign bus.desc_rdy     = rst_n && (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.stat_ctu_cnt = ctuCnt;
    assign bus.dbg_state    = state;

    // Address/data of the write that follows the one currently on the bus.
    always_comb begin
        nxtAddr = ADDR_START;
        nxtData = 32'h1;
        case (nxtIdx)
            3'd1:    begin nxtAddr = ADDR_SPS_0;          nxtData = sps0; end
            3'd2:    begin nxtAddr = ADDR_SPS_1;          nxtData = sps1; end
            3'd3:    begin nxtAddr = ADDR_PPS_0;          nxtData = pps0; end
            3'd4:    begin nxtAddr = ADDR_SLICE_HEADER_0; nxtData = sh0;  end
            default: begin nxtAddr = ADDR_START;          nxtData = 32'h1; end
        endcase
    end

    // Sequencer FSM with all bus and status outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wrIdx         <= 3'd0;
            vps0          <= '0;
            sps0          <= '0;
            sps1          <= '0;
            pps0          <= '0;
            sh0           <= '0;
            abortSeen     <= 1'b0;
            toCnt         <= '0;
            ctuCnt        <= 16'd0;
            bus.reg_wr    <= 1'b0;
            bus.reg_addr  <= 16'd0;
            bus.reg_wdata <= 32'd0;
            bus.stat_vld  <= 1'b0;
            bus.stat_code <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.desc_vld) begin
                        vps0          <= bus.desc_vps0;
                        sps0          <= bus.desc_sps0;
                        sps1          <= bus.desc_sps1;
                        pps0          <= bus.desc_pps0;
                        sh0           <= bus.desc_sh0;
                        ctuCnt        <= 16'd0;
                        wrIdx         <= 3'd0;
                        abortSeen     <= 1'b0;
                        bus.reg_wr    <= 1'b1;
                        bus.reg_addr  <= ADDR_VPS_0;
                        bus.reg_wdata <= bus.desc_vps0;
                        state         <= WR;
                    end
                end
                WR: begin
                    // An abort is remembered but the pending write always completes.
                    if (bus.reg_ack) begin
                        if (abortSeen || bus.abort) begin
                            bus.reg_wr    <= 1'b0;
                            bus.stat_code <= 2'd3;
                            bus.stat_vld  <= 1'b1;
                            state         <= REPORT;
                        end else if (wrIdx == 3'd5) begin
                            bus.reg_wr <= 1'b0;
                            toCnt      <= '0;
                            state      <= WAIT;
                        end else begin
                            wrIdx         <= nxtIdx;
                            bus.reg_addr  <= nxtAddr;
                            bus.reg_wdata <= nxtData;
                        end
                    end else if (bus.abort) begin
                        abortSeen <= 1'b1;
                    end
                end
                WAIT: begin
                    // A CTU pulse in the exit cycle still counts.
                    if (bus.cabac_ctu_done && ctuCnt != 16'hFFFF) begin
                        ctuCnt <= ctuCnt + 16'd1;
                    end
                    toCnt <= bus.cabac_ctu_done ? '0 : toCnt + TW'(1);
                    if (bus.cabac_error) begin
                        bus.stat_code <= 2'd1;
                        bus.stat_vld  <= 1'b1;
                        state         <= REPORT;
                    end else if (bus.cabac_done) begin
                        bus.stat_code <= 2'd0;
                        bus.stat_vld  <= 1'b1;
                        state         <= REPORT;
                    end else if (bus.abort) begin
                        bus.stat_code <= 2'd3;
                        bus.stat_vld  <= 1'b1;
                        state         <= REPORT;
                    end else if (toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus.stat_code <= 2'd2;
                        bus.stat_vld  <= 1'b1;
                        state         <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.stat_rdy) begin
                        bus.stat_vld <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qdec_cabac_slice_seq.sv
// Bench for the CABAC slice sequencer: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_qdec_cabac_slice_seq;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qdec_cabac_slice_seq_if bus();

    qdec_cabac_slice_seq #(.TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_delay = 0;

    // Reference model state (owned by the compare process).
    int          m_phase = 0;     // 0 idle, 1 writing, 2 waiting, 3 reporting
    logic [47:0] exp_q[$];        // pending {addr, data} writes of the slice
    logic [15:0] m_cnt = 16'd0;
    logic [1:0]  m_code = 2'd0;
    int          m_since = 0;
    bit          m_abort = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_fresh = 1'b0;

    // Observations of the current slice for the directed checks.
    logic [15:0] ack_addrs[$];
    logic [31:0] ack_data[$];
    int          wr_hi = 0;

    logic [15:0] ea[6] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014};
    logic [31:0] ed[6] = '{32'h0, 32'h033F_1DF0, 32'h0200_3233, 32'h001A_4290, 32'h0019_047E, 32'h1};

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Compare the DUT against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("desc_rdy", bus.desc_rdy, rst_n && m_phase == 0);
            chk("busy", bus.busy, m_phase != 0);
            chk("reg_wr", bus.reg_wr, m_phase == 1);
            if (m_phase == 1 && exp_q.size() > 0)
                chk("reg_addr_data", {bus.reg_addr, bus.reg_wdata}, exp_q[0]);
            if (m_fresh && m_phase == 0)
                chk("reg_addr_data_reset", {bus.reg_addr, bus.reg_wdata}, 48'd0);
            chk("stat_vld", bus.stat_vld, m_phase == 3);
            chk("stat_code", bus.stat_code, m_code);
            chk("stat_ctu_cnt", bus.stat_ctu_cnt, m_cnt);
        end
        if (m_phase == 1 && bus.reg_wr === 1'b1) wr_hi++;
        if (!rst_n) begin
            m_phase = 0;
            exp_q.delete();
            m_cnt   = 16'd0;
            m_code  = 2'd0;
            m_valid = 1'b1;
            m_fresh = 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                0: if (bus.desc_vld) begin
                    exp_q.delete();
                    exp_q.push_back({16'h0000, bus.desc_vps0});
                    exp_q.push_back({16'h0004, bus.desc_sps0});
                    exp_q.push_back({16'h0008, bus.desc_sps1});
                    exp_q.push_back({16'h000C, bus.desc_pps0});
                    exp_q.push_back({16'h0010, bus.desc_sh0});
                    exp_q.push_back({16'h0014, 32'h1});
                    m_cnt = 16'd0;
                    m_abort = 1'b0;
                    m_fresh = 1'b0;
                    m_phase = 1;
                    ack_addrs.delete();
                    ack_data.delete();
                    wr_hi = 0;
                end
                1: begin
                    if (bus.abort) m_abort = 1'b1;
                    if (bus.reg_ack) begin
                        ack_addrs.push_back(bus.reg_addr);
                        ack_data.push_back(bus.reg_wdata);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        if (m_abort) begin
                            exp_q.delete();
                            m_code = 2'd3;
                            m_phase = 3;
                        end else if (exp_q.size() == 0) begin
                            m_since = 0;
                            m_phase = 2;
                        end
                    end
                end
                2: begin
                    if (bus.cabac_ctu_done && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    if (bus.cabac_error) begin m_code = 2'd1; m_phase = 3; end
                    else if (bus.cabac_done) begin m_code = 2'd0; m_phase = 3; end
                    else if (bus.abort) begin m_code = 2'd3; m_phase = 3; end
                    else if (m_since == T - 1) begin m_code = 2'd2; m_phase = 3; end
                    m_since = bus.cabac_ctu_done ? 0 : m_since + 1;
                end
                default: if (bus.stat_rdy) m_phase = 0;
            endcase
        end
    end

    // Register-bus responder: ack each write after ack_delay wait cycles.
    initial begin
        int wc;
        wc = 0;
        bus.reg_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.reg_wr) begin
                if (wc >= ack_delay) begin
                    bus.reg_ack = 1'b1;
                    wc = 0;
                end else begin
                    bus.reg_ack = 1'b0;
                    wc++;
                end
            end else begin
                bus.reg_ack = 1'b0;
                wc = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_irq();
        bus.cabac_ctu_done = 1'b0;
        bus.cabac_error = 1'b0;
        bus.cabac_done = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic pulse(input bit ctu, input bit err, input bit done);
        bus.cabac_ctu_done = ctu;
        bus.cabac_error = err;
        bus.cabac_done = done;
        step();
        clear_irq();
    endtask

    task automatic send_desc(input logic [31:0] v, input logic [31:0] s0, input logic [31:0] s1,
                             input logic [31:0] p, input logic [31:0] h, output int acc);
        int n;
        n = 0;
        while (!bus.desc_rdy && n < 200) begin step(); n++; end
        chk("desc_rdy_bound", n < 200, 1);
        bus.desc_vps0 = v; bus.desc_sps0 = s0; bus.desc_sps1 = s1;
        bus.desc_pps0 = p; bus.desc_sh0 = h;
        bus.desc_vld = 1'b1;
        step();
        bus.desc_vld = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_in_wait(output int at);
        int n;
        n = 0;
        while (!(bus.busy && !bus.reg_wr && !bus.stat_vld) && n < 500) begin step(); n++; end
        chk("wait_entry_bound", n < 500, 1);
        at = cyc;
    endtask

    task automatic wait_stat(output int at);
        int n;
        n = 0;
        while (!bus.stat_vld && n < 500) begin step(); n++; end
        chk("stat_vld_bound", n < 500, 1);
        at = cyc;
    endtask

    task automatic finish_stat();
        bus.stat_rdy = 1'b1;
        step();
        bus.stat_rdy = 1'b0;
        chk("rdy_after_report", bus.desc_rdy, 1);
        chk("busy_after_report", bus.busy, 0);
    endtask

    initial begin
        int e, w, s, n;
        bus.desc_vld = 1'b0;
        bus.desc_vps0 = '0; bus.desc_sps0 = '0; bus.desc_sps1 = '0;
        bus.desc_pps0 = '0; bus.desc_sh0 = '0;
        bus.stat_rdy = 1'b0;
        clear_irq();
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("rdy_first_cycle", bus.desc_rdy, 1);
        chk("busy_reset", bus.busy, 0);
        chk("stat_vld_reset", bus.stat_vld, 0);

        // Nominal slice with immediate acks.
        ack_delay = 0;
        send_desc(32'h0, 32'h033F_1DF0, 32'h0200_3233, 32'h001A_4290, 32'h0019_047E, e);
        wait_in_wait(w);
        chk("nom_latency", w - e, 6);
        chk("nom_nwrites", ack_addrs.size(), 6);
        for (int i = 0; i < 6 && i < ack_addrs.size(); i++) begin
            chk("nom_addr", ack_addrs[i], ea[i]);
            chk("nom_data", ack_data[i], ed[i]);
        end
        repeat (3) pulse(1, 0, 0);
        pulse(0, 0, 1);
        chk("nom_vld", bus.stat_vld, 1);
        chk("nom_code", bus.stat_code, 0);
        chk("nom_cnt", bus.stat_ctu_cnt, 3);
        finish_stat();

        // Slow acks: each write held for five cycles.
        ack_delay = 4;
        send_desc($urandom(), $urandom(), $urandom(), $urandom(), $urandom(), e);
        wait_in_wait(w);
        chk("slow_latency", w - e, 30);
        chk("slow_wr_cycles", wr_hi, 30);
        chk("slow_nwrites", ack_addrs.size(), 6);
        pulse(0, 0, 1);
        chk("slow_code", bus.stat_code, 0);
        finish_stat();

        // Error beats done, with a CTU pulse in the same cycle.
        ack_delay = 0;
        send_desc($urandom(), $urandom(), $urandom(), $urandom(), $urandom(), e);
        wait_in_wait(w);
        repeat (2) pulse(1, 0, 0);
        pulse(1, 1, 1);
        chk("err_code", bus.stat_code, 1);
        chk("err_cnt", bus.stat_ctu_cnt, 3);
        finish_stat();

        // Timeout: one CTU at WAIT cycle 10, then silence.
        send_desc($urandom(), $urandom(), $urandom(), $urandom(), $urandom(), e);
        wait_in_wait(w);
        repeat (10) step();
        pulse(1, 0, 0);
        e = cyc;
        wait_stat(s);
        chk("to_delay", s - e, 16);
        chk("to_code", bus.stat_code, 2);
        chk("to_cnt", bus.stat_ctu_cnt, 1);
        finish_stat();

        // Abort while the SPS_1 write is pending.
        ack_delay = 3;
        send_desc($urandom(), $urandom(), $urandom(), $urandom(), $urandom(), e);
        n = 0;
        while (!(bus.reg_wr && bus.reg_addr == 16'h0008) && n < 100) begin step(); n++; end
        chk("abort_sps1_seen", n < 100, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        wait_stat(s);
        chk("abort_nwrites", ack_addrs.size(), 3);
        if (ack_addrs.size() > 0) chk("abort_last_addr", ack_addrs[ack_addrs.size() - 1], 16'h0008);
        chk("abort_code", bus.stat_code, 3);
        chk("abort_cnt", bus.stat_ctu_cnt, 0);

        // Backpressure on the status record.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_vld", bus.stat_vld, 1);
            chk("bp_code", bus.stat_code, 3);
            chk("bp_rdy", bus.desc_rdy, 0);
        end
        finish_stat();

        // Reset during WAIT.
        ack_delay = 0;
        send_desc($urandom(), $urandom(), $urandom(), $urandom(), $urandom(), e);
        wait_in_wait(w);
        repeat (2) pulse(1, 0, 0);
        rst_n = 1'b0;
        step();
        chk("rst_reg_wr", bus.reg_wr, 0);
        chk("rst_addr", bus.reg_addr, 0);
        chk("rst_wdata", bus.reg_wdata, 0);
        chk("rst_stat_vld", bus.stat_vld, 0);
        chk("rst_code", bus.stat_code, 0);
        chk("rst_cnt", bus.stat_ctu_cnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdy", bus.desc_rdy, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy_after", bus.desc_rdy, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if (i % 150 == 0) ack_delay = $urandom_range(0, 3);
            rst_n = ($urandom_range(0, 999) != 0);
            bus.desc_vld = ($urandom_range(0, 3) == 0);
            bus.desc_vps0 = $urandom(); bus.desc_sps0 = $urandom(); bus.desc_sps1 = $urandom();
            bus.desc_pps0 = $urandom(); bus.desc_sh0 = $urandom();
            bus.abort = ($urandom_range(0, 99) < 2);
            bus.cabac_done = ($urandom_range(0, 59) == 0);
            bus.cabac_error = ($urandom_range(0, 119) == 0);
            bus.cabac_ctu_done = ($urandom_range(0, 3) == 0);
            bus.stat_rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        rst_n = 1'b1;
        bus.desc_vld = 1'b0;
        clear_irq();
        bus.stat_rdy = 1'b1;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
